// File: rtl/ifq_pkg.sv
// Shared types, constants and sizing helpers for the instruction fetch queue.
// Optional misaligned-redirect fault support is enabled by IFQ_MISALIGN_CHECK_EN.
package ifq_pkg;

    localparam int unsigned IFQ_XLEN   = 32;
    localparam int unsigned ILEN_BYTES = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]         instr;
        logic [IFQ_XLEN-1:0] pc;
        logic                fault;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FS_RUN,
        FS_FAULT_PUSH,
        FS_HALT
    } fetch_state_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// In-order queue of fetch entries with flush; head is presented combinationally
// from storage (no bypass), so a push becomes visible the following cycle.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  fetch_entry_t                  wdata,
    input  logic                          pop,
    output fetch_entry_t                  rdata,
    output logic                          full,
    output logic                          empty,
    output logic [cnt_width(DEPTH)-1:0]   count
);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full queue may still accept.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// IF front end: credit-limited sequential fetch, in-order response queue, redirect flush.
// Define IFQ_MISALIGN_CHECK_EN to turn misaligned redirect targets into a single fault entry.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     XLEN     = IFQ_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            id_fault
);
    localparam int unsigned CW  = cnt_width(DEPTH);
    localparam int unsigned CW1 = CW + 1;
    // Stale responses can pile up over several redirects; headroom beyond one queue's worth.
    localparam int unsigned DW  = CW + 3;
    localparam logic [CW:0] CREDITS = CW1'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   occupancy;
    logic [DW-1:0]   drop_cnt;
    logic            stopped;
    logic            fault_push;
    logic            grant;
    logic            resp_drop;
    logic            resp_keep;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

`ifdef IFQ_MISALIGN_CHECK_EN
    fetch_state_t fstate;
    fetch_state_t fstate_n;
    logic         fault_halt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fstate <= FS_RUN;
        else       fstate <= fstate_n;
    end

    always_comb begin
        fstate_n = fstate;
        if (redirect_valid)
            fstate_n = (redirect_pc[1:0] != 2'b00) ? FS_FAULT_PUSH : FS_RUN;
        else if (fstate == FS_FAULT_PUSH)
            fstate_n = FS_HALT;
    end

    assign fault_halt = (fstate != FS_RUN);
    assign stopped    = fault_halt;
    assign fault_push = (fstate == FS_FAULT_PUSH) && !redirect_valid;
    assign target_pc  = redirect_pc;
`else
    assign stopped    = 1'b0;
    assign fault_push = 1'b0;
    assign target_pc  = redirect_pc & ~XLEN'(3);
`endif

    assign imem_req  = !reset && !redirect_valid && !stopped &&
                       (({1'b0, occupancy} + {1'b0, outstanding}) < CREDITS);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;
    assign resp_drop = (drop_cnt != '0);
    assign resp_keep = imem_rvalid && !resp_drop;
    // Live requests are consecutive words ending just below fetch_pc, so the
    // oldest one's PC is recovered arithmetically instead of being stored.
    assign resp_pc   = fetch_pc - XLEN'(outstanding) * XLEN'(ILEN_BYTES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= target_pc;
            outstanding <= '0;
            drop_cnt    <= drop_cnt + DW'(outstanding) - DW'(imem_rvalid);
        end else begin
            if (grant) fetch_pc <= fetch_pc + XLEN'(ILEN_BYTES);
            outstanding <= outstanding + CW'(grant) - CW'(resp_keep);
            if (imem_rvalid && resp_drop) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    always_comb begin
        push_entry.instr = imem_rdata;
        push_entry.pc    = IFQ_XLEN'(resp_pc);
        push_entry.fault = 1'b0;
        if (fault_push) begin
            push_entry.instr = NOP_INSTR;
            push_entry.pc    = IFQ_XLEN'(fetch_pc);
            push_entry.fault = 1'b1;
        end
    end

    assign fifo_push = !redirect_valid && (resp_keep || fault_push);
    assign fifo_pop  = id_valid && id_ready && !redirect_valid;

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .flush (redirect_valid),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    assign id_valid = !fifo_empty;
    assign id_instr = id_valid ? head.instr : '0;
    assign id_pc    = id_valid ? XLEN'(head.pc) : '0;

`ifdef IFQ_MISALIGN_CHECK_EN
    assign id_fault = id_valid && head.fault;
`else
    logic unused_fault;
    assign unused_fault = head.fault;
    assign id_fault     = 1'b0;
`endif

    overflow_chk: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized scoreboard bench for instr_fetch_queue with an in-order memory model.
module tb_instr_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_fault;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_fault       (id_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_t;

    exp_t        exp_q[$];   // entries the decode side should still see, oldest first
    logic [31:0] cur_q[$];   // addresses of live (non-stale) requests in flight
    mem_t        mem_q[$];   // every request the memory still owes a response for
    int unsigned stale;
    logic [31:0] next_pc;
    bit          halted;
    bit          fault_pend;
    logic [31:0] fault_pc;
    int unsigned cycle;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int unsigned p_gnt, p_ready, p_redir, lat_min, lat_max;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        if ($urandom_range(7) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(3) << 2);
        else                         t = 32'($urandom_range(32'h3FFF)) << 2;
        if ($urandom_range(3) == 0)  t[1:0] = 2'($urandom_range(3, 1));
        return t;
    endfunction

    // Monitor: every accepted decode handshake must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && id_valid && id_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_unexpected @cycle %0d: got pc %h expected no entry", cycle, id_pc);
            end else begin
                e = exp_q.pop_front();
                check("id_pc", id_pc, e.pc);
                check("id_instr", id_instr, e.instr);
                check("id_fault", 32'(id_fault), 32'(e.fault));
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        exp_q.delete(); cur_q.delete(); mem_q.delete();
        stale = 0; next_pc = RESET_PC; halted = 1'b0; fault_pend = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_fault", 32'(id_fault), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic step();
        int unsigned occ;
        logic        exp_req;
        logic [31:0] a;
        mem_t        m;
        @(posedge clk);
        #1;
        cycle++;
        check("id_valid", 32'(id_valid), 32'(exp_q.size() != 0));
        occ = exp_q.size() + cur_q.size();
        if (mem_q.size() != 0 && mem_q[0].due <= cycle) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt = ($urandom_range(99) < p_gnt);
        id_ready = ($urandom_range(99) < p_ready);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else begin
            redirect_valid = ($urandom_range(999) < p_redir);
            redirect_pc    = pick_target();
        end

        @(negedge clk);
        exp_req = !redirect_valid && !halted && (occ < DEPTH);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("imem_addr", imem_addr, next_pc);

        if (imem_req && imem_gnt)
            mem_q.push_back('{imem_addr, cycle + $urandom_range(lat_max, lat_min)});
        if (exp_req && imem_gnt) begin
            cur_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end

        if (imem_rvalid) begin
            m = mem_q.pop_front();
            if (stale != 0) begin
                stale--;
            end else if (!redirect_valid) begin
                if (cur_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL resp_unexpected @cycle %0d: got addr %h expected none", cycle, m.addr);
                end else begin
                    a = cur_q.pop_front();
                    exp_q.push_back('{word_of(a), a, 1'b0});
                end
            end
        end

        if (fault_pend && !redirect_valid) begin
            exp_q.push_back('{32'h0000_0013, fault_pc, 1'b1});
            fault_pend = 1'b0;
        end

        if (redirect_valid) begin
            exp_q.delete();
            cur_q.delete();
            stale = mem_q.size();
`ifdef IFQ_MISALIGN_CHECK_EN
            next_pc    = redirect_pc;
            halted     = (redirect_pc[1:0] != 2'b00);
            fault_pend = halted;
            fault_pc   = redirect_pc;
`else
            next_pc = {redirect_pc[31:2], 2'b00};
`endif
        end
    endtask

    task automatic knobs(input int unsigned g, input int unsigned r, input int unsigned d,
                         input int unsigned lmin, input int unsigned lmax);
        p_gnt = g; p_ready = r; p_redir = d; lat_min = lmin; lat_max = lmax;
    endtask

    initial begin
        cycle = 0;
        do_reset();

        // zero-wait memory, decode always ready
        knobs(100, 100, 0, 1, 1);
        repeat (40) step();

        // decode stalled: credits run out, then drain
        knobs(100, 0, 0, 1, 1);
        repeat (20) step();
        knobs(100, 100, 0, 1, 1);
        repeat (12) step();

        // latency 3, redirect with responses in flight
        knobs(100, 100, 0, 3, 3);
        repeat (6) step();
        force_redir = 1'b1; force_pc = 32'h0000_0100;
        repeat (15) step();

        // grant withheld, redirect during the stall
        knobs(0, 100, 0, 1, 2);
        repeat (5) step();
        force_redir = 1'b1; force_pc = 32'h0000_0040;
        step();
        knobs(100, 100, 0, 1, 2);
        repeat (10) step();

`ifdef IFQ_MISALIGN_CHECK_EN
        knobs(100, 100, 0, 1, 2);
        force_redir = 1'b1; force_pc = 32'h0000_0102;
        repeat (10) step();
        force_redir = 1'b1; force_pc = 32'h0000_0200;
        repeat (10) step();
`endif

        // mixed random traffic
        knobs(70, 60, 30, 1, 4);
        repeat (1500) step();

        // reset mid-operation
        do_reset();
        knobs(80, 70, 40, 1, 3);
        repeat (400) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
